// File: rtl/stack_seq.sv
// stack_seq: sequencer that expands one decoded PUSH/POP register-list
// instruction into single-word memory transfers followed by an SP update.
// It shares the data-memory port with execute and stalls fetch/decode while
// it runs.
//
// state  | meaning
// IDLE   | waiting for start; operands are latched on start
// SETUP  | one cycle: compute base address and first register
// XFER   | one memory transfer per register, advancing on mem_ack
// FINISH | one cycle: done pulse and SP write-back
module stack_seq #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_pop,
    input  logic [7:0]        r_list,
    input  logic              with_lr,
    input  logic [ADDR_W-1:0] sp_in,
    output logic              busy,
    output logic              done,
    output logic              stall,
    output logic [3:0]        count_out,
    output logic [3:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sp_we,
    output logic [ADDR_W-1:0] sp_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        XFER   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

    state_t state_q, state_d;

    logic              pop_q, pop_d;
    logic [7:0]        rem_q, rem_d;       // low registers not yet transferred
    logic              lr_q, lr_d;         // LR/PC transfer still pending
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [3:0]        n_q, n_d;           // total transfers for this op
    logic [3:0]        count_q, count_d;   // transfers remaining
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rf_we_q, rf_we_d;
    logic [3:0]        rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic [3:0]        cur;
    logic [ADDR_W-1:0] n_bytes;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Scan downward so the last hit is the lowest set bit.
    function automatic logic [3:0] lowest8(input logic [7:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Register currently being transferred: remaining low registers in
    // ascending order, then LR (store) or PC (load) at the highest address.
    always_comb begin
        if (rem_q != 8'd0) begin
            cur = lowest8(rem_q);
        end else begin
            cur = pop_q ? 4'd15 : 4'd14;
        end
        n_bytes = ADDR_W'(n_q) * STEP;
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pop_q      <= 1'b0;
            rem_q      <= 8'd0;
            lr_q       <= 1'b0;
            sp_q       <= '0;
            n_q        <= 4'd0;
            count_q    <= 4'd0;
            base_q     <= '0;
            addr_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 4'd0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            pop_q      <= pop_d;
            rem_q      <= rem_d;
            lr_q       <= lr_d;
            sp_q       <= sp_d;
            n_q        <= n_d;
            count_q    <= count_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        pop_d      = pop_q;
        rem_d      = rem_q;
        lr_d       = lr_q;
        sp_d       = sp_q;
        n_d        = n_q;
        count_d    = count_q;
        base_d     = base_q;
        addr_d     = addr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = 4'd0;
        rf_wdata_d = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pop_d   = is_pop;
                    rem_d   = r_list;
                    lr_d    = with_lr;
                    sp_d    = sp_in;
                    n_d     = popcount8(r_list) + {3'd0, with_lr};
                    count_d = n_d;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // PUSH pre-decrements SP by the whole block; wrap is allowed.
                base_d  = pop_q ? sp_q : (sp_q - n_bytes);
                addr_d  = base_d;
                state_d = (n_q == 4'd0) ? FINISH : XFER;
            end
            XFER: begin
                if (mem_ack) begin
                    count_d = count_q - 4'd1;
                    addr_d  = addr_q + STEP;
                    if (rem_q != 8'd0) begin
                        rem_d = rem_q & (rem_q - 8'd1);
                    end else begin
                        lr_d = 1'b0;
                    end
                    if (pop_q) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = cur;
                        rf_wdata_d = mem_rdata;
                    end
                    if (count_q == 4'd1) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state, so reset clears them at once.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == FINISH);
        sp_we     = (state_q == FINISH);
        stall     = reset & (busy | (start & (state_q == IDLE)));
        count_out = count_q;
        mem_req   = (state_q == XFER);
        mem_we    = mem_req & ~pop_q;
        mem_addr  = mem_req ? addr_q : '0;
        rf_raddr  = mem_we ? cur : 4'd0;
        mem_wdata = mem_we ? rf_rdata : '0;
        rf_we     = rf_we_q;
        rf_waddr  = rf_waddr_q;
        rf_wdata  = rf_wdata_q;
        sp_out    = '0;
        if (state_q == FINISH) begin
            sp_out = pop_q ? (sp_q + n_bytes) : base_q;
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
// Testbench for stack_seq: directed PUSH/POP vectors; expected memory
// transfers, register write-backs and SP updates are queued by the stimulus
// and consumed by an independent monitor.
module tb_stack_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_pop;
    logic [7:0]  r_list;
    logic        with_lr;
    logic [15:0] sp_in;
    logic        busy, done, stall;
    logic [3:0]  count_out;
    logic [3:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata;
    logic        sp_we;
    logic [15:0] sp_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        delay_en = 1'b0;
    logic [15:0] delay_addr = 16'h0;
    int          delay_len = 0;
    int          wait_cnt = 0;
    logic        pend = 1'b0;
    logic [15:0] pend_addr;
    logic [31:0] pend_wdata;

    logic [15:0] q_maddr[$];
    logic        q_mwe[$];
    logic [31:0] q_mdata[$];
    logic [3:0]  q_raddr[$];
    logic [31:0] q_rdata[$];
    logic [15:0] q_sp[$];

    stack_seq dut (
        .clk(clk), .reset(reset), .start(start), .is_pop(is_pop),
        .r_list(r_list), .with_lr(with_lr), .sp_in(sp_in),
        .busy(busy), .done(done), .stall(stall), .count_out(count_out),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .sp_we(sp_we),
        .sp_out(sp_out)
    );

    always #5 clk = ~clk;

    assign rf_rdata  = 32'hC0DE_0000 | {28'd0, rf_raddr};
    assign mem_rdata = mem_ack ? {16'hBEEF, mem_addr} : 32'd0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_mem(input logic [15:0] a, input logic we, input logic [31:0] d);
        q_maddr.push_back(a);
        q_mwe.push_back(we);
        q_mdata.push_back(d);
    endtask

    task automatic exp_rf(input logic [3:0] a, input logic [31:0] d);
        q_raddr.push_back(a);
        q_rdata.push_back(d);
    endtask

    // Memory model (ack, optional wait states on one address) plus monitor.
    always @(negedge clk) begin
        if (mem_req && delay_en && mem_addr == delay_addr && wait_cnt < delay_len) begin
            mem_ack = 1'b0;
            wait_cnt++;
        end else begin
            mem_ack  = mem_req;
            wait_cnt = 0;
        end
        if (mem_req && pend) begin
            chk("hold_addr", 64'(mem_addr), 64'(pend_addr));
            chk("hold_wdata", 64'(mem_wdata), 64'(pend_wdata));
        end
        pend       = mem_req && !mem_ack;
        pend_addr  = mem_addr;
        pend_wdata = mem_wdata;
        if (mem_req && mem_ack) begin
            if (q_maddr.size() == 0) begin
                chk("mem_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
            end else begin
                logic [15:0] ea;
                logic        ew;
                logic [31:0] ed;
                ea = q_maddr.pop_front();
                ew = q_mwe.pop_front();
                ed = q_mdata.pop_front();
                chk("mem_addr", 64'(mem_addr), 64'(ea));
                chk("mem_we", 64'(mem_we), 64'(ew));
                if (ew) chk("mem_wdata", 64'(mem_wdata), 64'(ed));
            end
        end
        if (rf_we) begin
            if (q_raddr.size() == 0) begin
                chk("rf_unexpected", 64'(rf_waddr), 64'hFFFF_FFFF);
            end else begin
                logic [3:0]  ra;
                logic [31:0] rd;
                ra = q_raddr.pop_front();
                rd = q_rdata.pop_front();
                chk("rf_waddr", 64'(rf_waddr), 64'(ra));
                chk("rf_wdata", 64'(rf_wdata), 64'(rd));
            end
        end
        if (sp_we) begin
            chk("done_with_sp_we", 64'(done), 64'd1);
            if (q_sp.size() == 0) begin
                chk("sp_unexpected", 64'(sp_out), 64'hFFFF_FFFF);
            end else begin
                logic [15:0] es;
                es = q_sp.pop_front();
                chk("sp_out", 64'(sp_out), 64'(es));
            end
        end
    end

    // Issue one op and compare per-cycle traces (bit k = cycle k after start).
    task automatic run_op(input string tag, input logic pop, input logic [7:0] list,
                          input logic lr, input logic [15:0] sp, input int exp_done,
                          input logic [15:0] exp_req, input logic [15:0] exp_rfwe,
                          input logic [63:0] exp_cnt, input int glitch_at);
        int          st;
        int          k;
        int          done_k;
        logic        seen;
        logic [15:0] busy_v, req_v, we_v, exp_busy;
        logic [63:0] cnt_v;
        busy_v = '0; req_v = '0; we_v = '0; cnt_v = '0;
        seen = 1'b0; done_k = -1;
        @(posedge clk); #1;
        start = 1'b1; is_pop = pop; r_list = list; with_lr = lr; sp_in = sp;
        st = cyc;
        #1 chk({tag, "_stall_start"}, 64'(stall), 64'd1);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            k = cyc - st;
            if (k < 16) begin
                busy_v[k] = busy;
                req_v[k]  = mem_req;
                we_v[k]   = rf_we;
                cnt_v[4*k +: 4] = count_out;
            end
            if (done) begin
                seen = 1'b1;
                done_k = k;
            end
            @(posedge clk); #1;
            if (glitch_at != 0 && (cyc - st) == glitch_at) begin
                start = 1'b1; is_pop = 1'b1; r_list = 8'hFF; with_lr = 1'b1; sp_in = 16'h1234;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_done_cycle"}, 64'(done_k), 64'(exp_done));
        exp_busy = ((16'd1 << (exp_done + 1)) - 16'd1) & 16'hFFFE;
        chk({tag, "_busy_trace"}, 64'(busy_v), 64'(exp_busy));
        chk({tag, "_req_trace"}, 64'(req_v), 64'(exp_req));
        chk({tag, "_rfwe_trace"}, 64'(we_v), 64'(exp_rfwe));
        chk({tag, "_count_trace"}, cnt_v, exp_cnt);
        @(negedge clk);
        chk({tag, "_idle_after"}, 64'({busy, stall, mem_req}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b1; is_pop = 1'b0; r_list = 8'hFF; with_lr = 1'b1; sp_in = 16'h0100;
        #3;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(count_out), 64'd0);
        chk("rst_mem", 64'({mem_req, mem_we, mem_addr, mem_wdata}), 64'd0);
        chk("rst_rf", 64'({rf_raddr, rf_we, rf_waddr, rf_wdata}), 64'd0);
        chk("rst_sp", 64'({sp_we, sp_out}), 64'd0);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // PUSH {r0,r1,lr}, SP 0x0100
        exp_mem(16'h00F4, 1'b1, 32'hC0DE_0000);
        exp_mem(16'h00F8, 1'b1, 32'hC0DE_0001);
        exp_mem(16'h00FC, 1'b1, 32'hC0DE_000E);
        q_sp.push_back(16'h00F4);
        run_op("push3", 1'b0, 8'h03, 1'b1, 16'h0100, 5, 16'h001C, 16'h0000, 64'h012330, 0);

        // POP {r4,r7,pc}, SP 0x00F0
        exp_mem(16'h00F0, 1'b0, 32'h0);
        exp_mem(16'h00F4, 1'b0, 32'h0);
        exp_mem(16'h00F8, 1'b0, 32'h0);
        exp_rf(4'd4, 32'hBEEF_00F0);
        exp_rf(4'd7, 32'hBEEF_00F4);
        exp_rf(4'd15, 32'hBEEF_00F8);
        q_sp.push_back(16'h00FC);
        run_op("pop3", 1'b1, 8'h90, 1'b1, 16'h00F0, 5, 16'h001C, 16'h0038, 64'h012330, 0);

        // PUSH {r0,r1}, second transfer waits 3 cycles for ack
        delay_en = 1'b1; delay_addr = 16'h01FC; delay_len = 3;
        exp_mem(16'h01F8, 1'b1, 32'hC0DE_0000);
        exp_mem(16'h01FC, 1'b1, 32'hC0DE_0001);
        q_sp.push_back(16'h01F8);
        run_op("delay", 1'b0, 8'h03, 1'b0, 16'h0200, 7, 16'h007C, 16'h0000, 64'h0111_1220, 0);
        delay_en = 1'b0;

        // Empty list: no transfers
        q_sp.push_back(16'h0300);
        run_op("empty", 1'b0, 8'h00, 1'b0, 16'h0300, 2, 16'h0000, 16'h0000, 64'h0, 0);

        // PUSH {r0-r2} with SP wrapping below zero
        exp_mem(16'hFFF8, 1'b1, 32'hC0DE_0000);
        exp_mem(16'hFFFC, 1'b1, 32'hC0DE_0001);
        exp_mem(16'h0000, 1'b1, 32'hC0DE_0002);
        q_sp.push_back(16'hFFF8);
        run_op("wrap", 1'b0, 8'h07, 1'b0, 16'h0004, 5, 16'h001C, 16'h0000, 64'h012330, 0);

        // start pulsed while busy is ignored
        exp_mem(16'h03FC, 1'b1, 32'hC0DE_0000);
        q_sp.push_back(16'h03FC);
        run_op("glitch", 1'b0, 8'h01, 1'b0, 16'h0400, 3, 16'h0004, 16'h0000, 64'h0110, 2);

        // Reset during XFER: one transfer completes, second is aborted
        exp_mem(16'h04F0, 1'b1, 32'hC0DE_0000);
        @(posedge clk); #1;
        start = 1'b1; is_pop = 1'b0; r_list = 8'h0F; with_lr = 1'b0; sp_in = 16'h0500;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pre_req", 64'({mem_req, mem_addr}), 64'h1_04F4);
        reset = 1'b0;
        #1;
        chk("abort_req", 64'(mem_req), 64'd0);
        chk("abort_outs", 64'({busy, done, stall, count_out, mem_addr, sp_we}), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Normal POP {r0} after reset release
        exp_mem(16'h0600, 1'b0, 32'h0);
        exp_rf(4'd0, 32'hBEEF_0600);
        q_sp.push_back(16'h0604);
        run_op("post_rst", 1'b1, 8'h01, 1'b0, 16'h0600, 3, 16'h0004, 16'h0008, 64'h0110, 0);

        repeat (3) @(posedge clk);
        chk("q_mem_empty", 64'(q_maddr.size()), 64'd0);
        chk("q_rf_empty", 64'(q_raddr.size()), 64'd0);
        chk("q_sp_empty", 64'(q_sp.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
